// File: rtl/spi_rx_fifo_pkg.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo_pkg
//  Shared constants for the SPI-receive -> MIDI-UART byte path:
//  - default word width and FIFO depth
//  - width and saturation value of the optional drop counter
//    (used when SPI_RX_FIFO_DROP_CNT_EN is defined)
// -----------------------------------------------------------------------------
package spi_rx_fifo_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_DEPTH_LOG2 = 4;

    localparam int                    DROP_CNT_W   = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage : spi_rx_fifo_pkg

// File: rtl/spi_rx_fifo_mem.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo_mem
//  Register-array storage for spi_rx_fifo. One synchronous write port and one
//  asynchronous (combinational) read port. The array is not reset.
//  Ports:
//    clk    in   system clock
//    we     in   write enable
//    waddr  in   write address
//    wdata  in   write data
//    raddr  in   read address
//    rdata  out  mem[raddr], combinational
// -----------------------------------------------------------------------------
module spi_rx_fifo_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [DEPTH_LOG2-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule : spi_rx_fifo_mem

// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
//  Byte FIFO between the SPI slave receiver and the MIDI UART transmitter.
//  Each wr_stb pulse stores one frame; the consumer drains with a show-ahead
//  valid/ready handshake. Writes arriving while full (and not coinciding with
//  a read) are dropped and flagged in the sticky overflow bit.
//  Build option: define SPI_RX_FIFO_DROP_CNT_EN to add the saturating
//  drop_cnt output.
//  Ports:
//    clk       in   system clock, rising edge
//    rst_n     in   asynchronous active-low reset
//    wr_data   in   frame from SPI receiver, valid with wr_stb
//    wr_stb    in   one-clk write strobe
//    rd_data   out  head-of-FIFO word (valid when rd_valid)
//    rd_valid  out  FIFO non-empty
//    rd_ready  in   consumer takes head word this cycle
//    count     out  stored words, 0..2**DEPTH_LOG2
//    full      out  count == depth
//    overflow  out  sticky lost-byte flag
//    ovf_clr   in   one-clk pulse clearing overflow (and drop_cnt)
//    drop_cnt  out  [optional] saturating count of dropped writes
// -----------------------------------------------------------------------------
module spi_rx_fifo
    import spi_rx_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_stb,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  overflow,
    input  logic                  ovf_clr
`ifdef SPI_RX_FIFO_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] drop_cnt
`endif
);

    localparam int                    DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE   = DEPTH_LOG2'(1);

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  rd_fire;
    logic                  wr_fire;
    logic                  wr_drop;

    // Flags come straight from the count register, so they never glitch on
    // same-cycle read/write activity.
    assign rd_valid = (count_q != '0);
    assign full     = (count_q == DEPTH_CNT);
    assign count    = count_q;

    // A read in the same cycle frees a slot, so a full FIFO still accepts.
    assign rd_fire = rd_valid & rd_ready;
    assign wr_fire = wr_stb & (~full | rd_fire);
    assign wr_drop = wr_stb & ~wr_fire;

    spi_rx_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clk   (clk),
        .we    (wr_fire),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_fire, rd_fire})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: ;
            endcase
            // A new drop outranks a coincident clear.
            if (wr_drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

`ifdef SPI_RX_FIFO_DROP_CNT_EN
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == DROP_CNT_MAX) ? v : v + DROP_CNT_W'(1);
    endfunction

    // A clear coinciding with a drop leaves that one drop counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (ovf_clr) begin
            drop_cnt <= wr_drop ? DROP_CNT_W'(1) : '0;
        end else if (wr_drop) begin
            drop_cnt <= sat_inc(drop_cnt);
        end
    end
`endif

endmodule : spi_rx_fifo

// File: tb/tb_spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_fifo
//  Self-checking bench for spi_rx_fifo. A queue-based reference model tracks
//  the expected contents, overflow flag and (optionally) drop counter.
// -----------------------------------------------------------------------------
module tb_spi_rx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] wr_data;
    logic       wr_stb;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [4:0] count;
    logic       full;
    logic       overflow;
    logic       ovf_clr;
`ifdef SPI_RX_FIFO_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf;
    int         m_drop;

    spi_rx_fifo dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_data  (wr_data),
        .wr_stb   (wr_stb),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ready (rd_ready),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .ovf_clr  (ovf_clr)
`ifdef SPI_RX_FIFO_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Drive one clock cycle of inputs and advance the model across the edge.
    task automatic cycle(input bit w, input logic [7:0] d, input bit r, input bit c);
        bit take, accept, drop;
        wr_stb   = w;
        wr_data  = d;
        rd_ready = r;
        ovf_clr  = c;
        take   = r && (mq.size() > 0);
        accept = w && ((mq.size() < DEPTH) || take);
        drop   = w && !accept;
        @(posedge clk);
        if (take) void'(mq.pop_front());
        if (accept) mq.push_back(d);
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        if (c) m_drop = drop ? 1 : 0;
        else if (drop) m_drop = (m_drop >= 255) ? 255 : m_drop + 1;
        #1;
        wr_stb  = 1'b0;
        rd_ready = 1'b0;
        ovf_clr = 1'b0;
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr_stb = 1'b0; wr_data = '0; rd_ready = 1'b0; ovf_clr = 1'b0;
        model_reset();
        #2;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: count=%0d valid=%b full=%b ovf=%b, want 0 0 0 0",
                     count, rd_valid, full, overflow);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        // Mid-burst reset after the FIFO has filled and overflowed
        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL reset_prefill: ovf=%b full=%b, want 1 1", overflow, full);
        end
        wr_stb = 1'b1; wr_data = 8'h3C;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: count=%0d valid=%b full=%b ovf=%b, want 0 0 0 0",
                     count, rd_valid, full, overflow);
        end
        wr_stb = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        cycle(1'b1, 8'h90, 1'b0, 1'b0);
        checks++;
        if (rd_valid !== 1'b1 || rd_data !== 8'h90 || count !== 5'd1) begin
            errors++;
            $display("FAIL single_write: valid=%b data=%h count=%0d, want 1 90 1",
                     rd_valid, rd_data, count);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0) begin
            errors++;
            $display("FAIL single_read: valid=%b count=%0d, want 0 0", rd_valid, count);
        end
    endtask

    task automatic test_empty_edges();
        // Read request on empty FIFO is ignored
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd0 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_read: count=%0d valid=%b, want 0 0", count, rd_valid);
        end
        // Write plus read on empty: no bypass, byte stays stored
        cycle(1'b1, 8'hC3, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd1 || rd_data !== 8'hC3) begin
            errors++;
            $display("FAIL empty_nobypass: count=%0d data=%h, want 1 c3", count, rd_data);
        end
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (count !== 5'(mq.size())) begin
            errors++;
            $display("FAIL empty_drain: count=%0d, want %0d", count, mq.size());
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill: full=%b count=%0d ovf=%b, want 1 16 0", full, count, overflow);
        end
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            errors++;
            $display("FAIL fill_drop: ovf=%b count=%0d, want 1 16", overflow, count);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== 8'(i)) begin
                errors++;
                $display("FAIL fill_drain[%0d]: valid=%b data=%h, want 1 %h", i, rd_valid, rd_data, 8'(i));
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (rd_valid !== 1'b0 || count !== 5'd0 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_empty: valid=%b count=%0d ovf=%b, want 0 0 1", rd_valid, count, overflow);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr: ovf=%b, want 0", overflow);
        end
    endtask

    task automatic test_full_rdwr();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
            errors++;
            $display("FAIL full_rdwr: count=%0d ovf=%b full=%b, want 16 0 1", count, overflow, full);
        end
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== mq[0]) begin
                errors++;
                $display("FAIL full_rdwr_drain[%0d]: valid=%b data=%h, want 1 %h", i, rd_valid, rd_data, mq[0]);
            end
            if (i == DEPTH - 1) begin
                checks++;
                if (rd_data !== 8'h55) begin
                    errors++;
                    $display("FAIL full_rdwr_last: data=%h, want 55", rd_data);
                end
            end
            cycle(1'b0, 8'h00, 1'b1, 1'b0);
        end
        // Clear coinciding with a new drop: drop wins
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 8'hEE, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL clr_vs_drop: ovf=%b, want 1", overflow);
        end
        while (mq.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_wrap();
        int  writes = 0;
        int  guard  = 0;
        bit  rtog   = 1'b0;
        while ((writes < 40 || mq.size() > 0) && guard < 2000) begin
            bit w;
            guard++;
            w = (writes < 40) && ($urandom_range(0, 1) == 1);
            if (mq.size() > 0) begin
                checks++;
                if (rd_valid !== 1'b1 || rd_data !== mq[0]) begin
                    errors++;
                    $display("FAIL wrap_head: valid=%b data=%h, want 1 %h", rd_valid, rd_data, mq[0]);
                end
            end
            rtog = (writes >= 40) ? 1'b1 : ~rtog;
            cycle(w, 8'($urandom), rtog, 1'b0);
            if (w) writes++;
            checks++;
            if (count !== 5'(mq.size()) || count > 5'd16 || overflow !== m_ovf) begin
                errors++;
                $display("FAIL wrap_state: count=%0d ovf=%b, want %0d %b", count, overflow, mq.size(), m_ovf);
            end
        end
        checks++;
        if (guard >= 2000 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: guard=%0d valid=%b, want <2000 0", guard, rd_valid);
        end
    endtask

`ifdef SPI_RX_FIFO_DROP_CNT_EN
    task automatic test_drop_cnt();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 8'($urandom), 1'b0, 1'b0);
        checks++;
        if (drop_cnt !== 8'hFF || overflow !== 1'b1 || drop_cnt !== 8'(m_drop)) begin
            errors++;
            $display("FAIL drop_sat: cnt=%h ovf=%b, want ff 1", drop_cnt, overflow);
        end
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (drop_cnt !== 8'h00 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL drop_clr: cnt=%h ovf=%b, want 00 0", drop_cnt, overflow);
        end
        cycle(1'b1, 8'h11, 1'b0, 1'b0);
        cycle(1'b1, 8'h22, 1'b0, 1'b1);
        checks++;
        if (drop_cnt !== 8'h01 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL drop_clr_coinc: cnt=%h ovf=%b, want 01 1", drop_cnt, overflow);
        end
        while (mq.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_empty_edges();
        test_fill_overflow();
        test_full_rdwr();
        test_wrap();
`ifdef SPI_RX_FIFO_DROP_CNT_EN
        test_drop_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_spi_rx_fifo
